// File: rtl/data_mem_responder_if.sv
// Request/response bus between a core load/store unit and the data memory responder.
// The master is the core and the slave is the responder.
interface data_mem_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [DATA_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency RV32I data memory model: one outstanding request, little-endian word array.
// Accepted requests are executed LATENCY edges later and held until the core takes the response.
//
//   state  | meaning
//   IDLE   | ready for a request (req_ready=1)
//   WAIT   | latency counter running; access happens on the edge it reaches 0
//   RESP   | response registered, held until rsp_ready
module data_mem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    data_mem_if.slave bus
);
    localparam int                IDX_W     = DATA_WIDTH - 2;
    localparam int                MEM_AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]        LAT_LD    = 4'(LATENCY);
    localparam logic [IDX_W:0]    DEPTH_LIM = (IDX_W + 1)'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    logic                  accept;
    logic                  commit;
    logic                  wr_en;
    logic [IDX_W-1:0]      word_idx;
    logic [MEM_AW-1:0]     mem_idx;
    logic                  oor;
    logic [DATA_WIDTH-1:0] word_rd;
    logic [7:0]            byte_v;
    logic [15:0]           half_v;
    logic                  acc_err;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] st_data;
    logic [DATA_WIDTH-1:0] ld_data;

    assign word_idx = addr_q[DATA_WIDTH-1:2];
    assign mem_idx  = word_idx[MEM_AW-1:0];
    assign oor      = {1'b0, word_idx} >= DEPTH_LIM;
    assign commit   = (state_q == S_WAIT) && (cnt_q <= 4'd1);
    assign wr_en    = commit && we_q && !acc_err && rst_n;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = LAT_LD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (commit) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Decode of the captured request: legality, write lanes and extended load value.
    always_comb begin
        word_rd = mem[mem_idx];
        byte_v  = 8'(word_rd >> {addr_q[1:0], 3'b000});
        half_v  = addr_q[1] ? word_rd[31:16] : word_rd[15:0];
        acc_err = 1'b0;
        be      = 4'b0000;
        st_data = wdata_q;
        ld_data = '0;
        case (f3_q)
            3'b000: begin
                be      = 4'b0001 << addr_q[1:0];
                st_data = DATA_WIDTH'({4{wdata_q[7:0]}});
                ld_data = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
            end
            3'b100: begin
                acc_err = we_q;
                ld_data = {{(DATA_WIDTH-8){1'b0}}, byte_v};
            end
            3'b001: begin
                acc_err = addr_q[0];
                be      = addr_q[1] ? 4'b1100 : 4'b0011;
                st_data = DATA_WIDTH'({2{wdata_q[15:0]}});
                ld_data = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
            end
            3'b101: begin
                acc_err = we_q | addr_q[0];
                ld_data = {{(DATA_WIDTH-16){1'b0}}, half_v};
            end
            3'b010: begin
                acc_err = |addr_q[1:0];
                be      = 4'b1111;
                ld_data = word_rd;
            end
            default: acc_err = 1'b1;
        endcase
        if (oor) begin
            acc_err = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            f3_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= bus.req_we;
                f3_q    <= bus.req_funct3;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (commit) begin
                rsp_err_q   <= acc_err;
                rsp_rdata_q <= (acc_err || we_q) ? '0 : ld_data;
            end
        end
    end

    // Array has no reset; a store aborted by reset never reaches this enable.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[mem_idx][8*i +: 8] <= st_data[8*i +: 8];
                end
            end
        end
    end

    assign bus.req_ready = (state_q == S_IDLE) && rst_n;
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, giving the data and address width in bits.
REQ-002 The module SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit words in the internal array.
REQ-003 The module SHALL have parameter LATENCY, default 2, giving the cycles from request acceptance to response valid; legal range 1..15.
REQ-004 The module SHALL have one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req_valid  input  1  core presents a memory request.
REQ-008 req_ready  output  1  responder can accept a request.
REQ-009 req_we  input  1  1 = store, 0 = load.
REQ-010 req_funct3  input  3  RV32I load/store width/sign code.
REQ-011 req_addr  input  DATA_WIDTH  byte address.
REQ-012 req_wdata  input  DATA_WIDTH  store data, right-aligned.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  core accepts the response.
REQ-015 rsp_rdata  output  DATA_WIDTH  load result, extended to 32 bits; 0 for stores and errors.
REQ-016 rsp_err  output  1  access faulted; no state was changed.

Function
REQ-017 The FSM SHALL have the states IDLE, WAIT and RESP, with exactly one request outstanding at a time.
REQ-018 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge where req_valid and req_ready are both 1.
REQ-019 On acceptance the module SHALL capture addr, we, funct3 and wdata, load the latency counter with LATENCY, and enter WAIT.
REQ-020 In WAIT the counter SHALL decrement each cycle; on the edge where it reaches 0, the module SHALL perform the access, register rsp_rdata and rsp_err, and enter RESP, so that rsp_valid rises exactly LATENCY edges after acceptance.
REQ-021 In RESP, rsp_valid SHALL be 1, and rsp_rdata and rsp_err SHALL be held stable until rsp_ready=1 is sampled; the module then returns to IDLE, with req_ready=1 on the following cycle.
REQ-022 Input changes while not in IDLE SHALL be ignored.
REQ-023 The array SHALL be little-endian and indexed by addr[31:2]; byte lane = addr[1:0].
REQ-024 Stores: funct3 000 (SB) writes lane addr[1:0] with wdata[7:0]; 001 (SH) writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0]; 010 (SW) writes all four lanes; other lanes are unchanged.
REQ-025 Loads: 000 LB sign-extends the byte; 100 LBU zero-extends it; 001 LH sign-extends the halfword; 101 LHU zero-extends it; 010 LW returns the word.
REQ-026 Error, with rsp_err=1, rsp_rdata=0 and no write, SHALL occur on:
  - a halfword access with addr[0]=1;
  - a word access with addr[1:0]!=00;
  - funct3 in {011,110,111}, or a store with funct3 in {100,101};
  - addr[31:2] >= DEPTH_WORDS.
REQ-027 Stores SHALL return rsp_rdata=0 and rsp_err=0 when legal.
REQ-028 A store SHALL commit only on the WAIT-to-RESP edge; a read-after-write to the same word issued after the store's response SHALL see the new data.

Reset
REQ-029 While rst_n=0, the module SHALL hold state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 and req_ready=0, and SHALL set req_ready=1 in the first cycle after deassertion.
REQ-030 Reset asserted in WAIT SHALL discard the pending request; a pending store SHALL not be committed.
REQ-031 Reset asserted in RESP SHALL drop the response without a handshake.
REQ-032 Array contents SHALL NOT be affected by reset and are undefined until written.

Verification
REQ-033 SW 0xDEADBEEF at 0x40, then LW 0x40 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid rising exactly 2 edges after each acceptance.
REQ-034 After REQ-033, LB 0x43 -> 0xFFFFFFDE; LBU 0x43 -> 0x000000DE; LH 0x42 -> 0xFFFFDEAD; LHU 0x40 -> 0x0000BEEF; then SB 0x41 with wdata 0x12 followed by LW 0x40 -> 0xDEAD12EF.
REQ-035 LW 0x42, LH 0x41, funct3=011, and SW to byte address 4*DEPTH_WORDS -> each returns rsp_err=1 and rsp_rdata=0; a subsequent LW 0x40 is unchanged.
REQ-036 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stay constant and req_ready=0; raise rsp_ready -> IDLE next cycle.
REQ-037 Issue SW 0x11111111 at 0x80, then assert rst_n=0 one cycle after acceptance; after reset, LW 0x80 -> the prior value, not 0x11111111; outputs are at their reset values during reset.
